// File: rtl/uart_bus_master.sv
// Serial debug bridge: decodes UART command frames into 16-bit bus initiator cycles and
// returns read data / status bytes through the UART transmitter.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_active,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_data_write,
    input  logic [15:0]       bus_data_read,
    output logic              bus_rw,
    output logic              bus_uds,
    output logic              bus_lds,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic              busy,
    output logic              rx_drop
);

    localparam logic [7:0] CmdRdWord  = 8'h52;
    localparam logic [7:0] CmdWrWord  = 8'h57;
    localparam logic [7:0] CmdRdByte  = 8'h62;
    localparam logic [7:0] CmdWrByte  = 8'h42;
    localparam logic [7:0] RspOk      = 8'h4B;
    localparam logic [7:0] RspTimeout = 8'h54;
    localparam logic [7:0] RspBadCmd  = 8'h3F;
    localparam logic [15:0] TmoLast   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StA2, StA1, StA0, StD1, StD0, StBus, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        dhi_q, dhi_d;
    logic [7:0]        dlo_q, dlo_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [15:0]       bus_data_write_q, bus_data_write_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              bus_rw_q, bus_rw_d;
    logic              bus_uds_q, bus_uds_d;
    logic              bus_lds_q, bus_lds_d;
    logic              bus_req_q, bus_req_d;
    logic [2:0][7:0]   rsp_q, rsp_d;
    logic [1:0]        rsp_cnt_q, rsp_cnt_d;
    logic [1:0]        tx_hist_q, tx_hist_d;
    logic              start_bus;
    logic              is_word;

    assign is_word = (cmd_q == CmdRdWord) || (cmd_q == CmdWrWord);

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        addr_d           = addr_q;
        dhi_d            = dhi_q;
        dlo_d            = dlo_q;
        bus_addr_d       = bus_addr_q;
        bus_data_write_d = bus_data_write_q;
        bus_rw_d         = bus_rw_q;
        bus_uds_d        = bus_uds_q;
        bus_lds_d        = bus_lds_q;
        bus_req_d        = bus_req_q;
        tmo_d            = tmo_q;
        rsp_d            = rsp_q;
        rsp_cnt_d        = rsp_cnt_q;
        start_bus        = 1'b0;
        rx_drop          = 1'b0;

        // Two quiet cycles after each start cover the transmitter's registration latency.
        tx_start  = (state_q == StResp) && (rsp_cnt_q != 2'd0) && !tx_active &&
                    (tx_hist_q == 2'b00);
        tx_hist_d = {tx_hist_q[0], tx_start};
        tx_data_d = tx_start ? rsp_q[0] : tx_data_q;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if ((rx_data == CmdRdWord) || (rx_data == CmdWrWord) ||
                        (rx_data == CmdRdByte) || (rx_data == CmdWrByte)) begin
                        cmd_d   = rx_data;
                        state_d = StA2;
                    end else begin
                        rsp_d     = {16'h0000, RspBadCmd};
                        rsp_cnt_d = 2'd1;
                        state_d   = StResp;
                    end
                end
            end
            StA2, StA1: begin
                if (rx_valid) begin
                    addr_d  = {addr_q[ADDR_W-9:0], rx_data};
                    state_d = (state_q == StA2) ? StA1 : StA0;
                end
            end
            StA0: begin
                if (rx_valid) begin
                    addr_d = {addr_q[ADDR_W-9:0], rx_data};
                    if (cmd_q == CmdWrWord) begin
                        state_d = StD1;
                    end else if (cmd_q == CmdWrByte) begin
                        state_d = StD0;
                    end else begin
                        state_d   = StBus;
                        start_bus = 1'b1;
                    end
                end
            end
            StD1: begin
                if (rx_valid) begin
                    dhi_d   = rx_data;
                    state_d = StD0;
                end
            end
            StD0: begin
                if (rx_valid) begin
                    dlo_d     = rx_data;
                    state_d   = StBus;
                    start_bus = 1'b1;
                end
            end
            StBus: begin
                rx_drop = rx_valid;
                if (bus_req_q) begin
                    if (bus_ack) begin
                        bus_req_d = 1'b0;
                        state_d   = StResp;
                        case (cmd_q)
                            CmdRdWord: begin
                                rsp_d     = {RspOk, bus_data_read[7:0], bus_data_read[15:8]};
                                rsp_cnt_d = 2'd3;
                            end
                            CmdRdByte: begin
                                rsp_d     = {8'h00, RspOk,
                                             addr_q[0] ? bus_data_read[7:0] : bus_data_read[15:8]};
                                rsp_cnt_d = 2'd2;
                            end
                            default: begin
                                rsp_d     = {16'h0000, RspOk};
                                rsp_cnt_d = 2'd1;
                            end
                        endcase
                    end else if (tmo_q == TmoLast) begin
                        bus_req_d = 1'b0;
                        state_d   = StResp;
                        rsp_d     = {16'h0000, RspTimeout};
                        rsp_cnt_d = 2'd1;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            StResp: begin
                rx_drop = rx_valid;
                if (tx_start) begin
                    rsp_d     = {8'h00, rsp_q[2], rsp_q[1]};
                    rsp_cnt_d = rsp_cnt_q - 2'd1;
                    if (rsp_cnt_q == 2'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus outputs are loaded from the next-state address/data so they go live one cycle
        // after the final frame byte.
        if (start_bus) begin
            bus_req_d  = 1'b1;
            tmo_d      = '0;
            bus_rw_d   = (cmd_q == CmdRdWord) || (cmd_q == CmdRdByte);
            bus_addr_d = is_word ? {addr_d[ADDR_W-1:1], 1'b0} : addr_d;
            bus_uds_d  = is_word || !addr_d[0];
            bus_lds_d  = is_word || addr_d[0];
            case (cmd_q)
                CmdWrWord: bus_data_write_d = {dhi_d, dlo_d};
                CmdWrByte: bus_data_write_d = {dlo_d, dlo_d};
                default:   bus_data_write_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            cmd_q            <= '0;
            addr_q           <= '0;
            dhi_q            <= '0;
            dlo_q            <= '0;
            tx_data_q        <= '0;
            bus_addr_q       <= '0;
            bus_data_write_q <= '0;
            bus_rw_q         <= 1'b0;
            bus_uds_q        <= 1'b0;
            bus_lds_q        <= 1'b0;
            bus_req_q        <= 1'b0;
            tmo_q            <= '0;
            rsp_q            <= '0;
            rsp_cnt_q        <= '0;
            tx_hist_q        <= '0;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            addr_q           <= addr_d;
            dhi_q            <= dhi_d;
            dlo_q            <= dlo_d;
            tx_data_q        <= tx_data_d;
            bus_addr_q       <= bus_addr_d;
            bus_data_write_q <= bus_data_write_d;
            bus_rw_q         <= bus_rw_d;
            bus_uds_q        <= bus_uds_d;
            bus_lds_q        <= bus_lds_d;
            bus_req_q        <= bus_req_d;
            tmo_q            <= tmo_d;
            rsp_q            <= rsp_d;
            rsp_cnt_q        <= rsp_cnt_d;
            tx_hist_q        <= tx_hist_d;
        end
    end

    assign tx_data        = tx_data_d;
    assign bus_addr       = bus_addr_q;
    assign bus_data_write = bus_data_write_q;
    assign bus_rw         = bus_rw_q;
    assign bus_uds        = bus_uds_q;
    assign bus_lds        = bus_lds_q;
    assign bus_req        = bus_req_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: host frames, responding slave and transmitter models, with
// expected bus cycles and response bytes derived from the command rules.
module tb_uart_bus_master;

    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_active = 1'b0;
    logic [23:0] bus_addr;
    logic [15:0] bus_data_write;
    logic [15:0] bus_data_read = '0;
    logic        bus_rw;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic        rx_drop;

    uart_bus_master #(
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W        (24)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_active     (tx_active),
        .bus_addr      (bus_addr),
        .bus_data_write(bus_data_write),
        .bus_data_read (bus_data_read),
        .bus_rw        (bus_rw),
        .bus_uds       (bus_uds),
        .bus_lds       (bus_lds),
        .bus_req       (bus_req),
        .bus_ack       (bus_ack),
        .busy          (busy),
        .rx_drop       (rx_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave model: acks on the ack_delay-th cycle after bus_req rises (never if negative).
    int          ack_delay = -1;
    logic [15:0] rd_data = '0;
    int          req_cycles = 0;
    int          req_count = 0;
    int          req_len = 0;
    logic [42:0] snap = '0;
    bit          ack_next;
    bit          junk_ack;

    initial begin
        forever begin
            @(negedge clk);
            ack_next = 1'b0;
            junk_ack = 1'b0;
            if (bus_req) begin
                if (req_cycles == 0)
                    snap = {bus_addr, bus_rw, bus_uds, bus_lds, bus_data_write};
                else
                    check_eq("bus_hold", {bus_addr, bus_rw, bus_uds, bus_lds, bus_data_write}, snap);
                req_cycles++;
                ack_next = (req_cycles == ack_delay);
            end else begin
                if (req_cycles > 0) begin
                    req_count++;
                    req_len    = req_cycles;
                    req_cycles = 0;
                end
                junk_ack = !busy && ($urandom_range(0, 4) == 0);
            end
            @(posedge clk);
            #1;
            bus_ack       = ack_next || junk_ack;
            bus_data_read = ack_next ? rd_data : 16'($urandom);
        end
    end

    // Transmitter model: busy for a random 0..6 cycles, starting the cycle after tx_start.
    logic [7:0] txq[$];
    int         last_start = -100;
    logic [7:0] held = '0;
    bit         have_tx = 1'b0;
    int         tx_left = 0;
    bit         start_now;

    initial begin
        forever begin
            @(negedge clk);
            start_now = tx_start;
            if (tx_start) begin
                check_eq("tx_idle_at_start", tx_active, 1'b0);
                check_eq("tx_start_gap", (cyc - last_start) >= 3, 1'b1);
                last_start = cyc;
                txq.push_back(tx_data);
                held    = tx_data;
                have_tx = 1'b1;
            end else if (have_tx && reset_n) begin
                check_eq("tx_data_hold", tx_data, held);
            end
            @(posedge clk);
            #1;
            if (start_now) begin
                tx_left   = $urandom_range(0, 6);
                tx_active = (tx_left > 0);
            end else if (tx_left > 0) begin
                tx_left--;
                tx_active = (tx_left > 0);
            end
        end
    end

    // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic send_byte(input logic [7:0] b, output logic dropped);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        dropped = rx_drop;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] cmd, input logic [23:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata,
                          input int delay, input bit inject);
        logic [7:0]  frame[$];
        logic [7:0]  exp_tx[$];
        bit          known;
        bit          word;
        bit          wr;
        logic [23:0] exp_addr;
        logic [15:0] exp_wdata;
        logic        dropped;
        int          n;

        known = (cmd == 8'h52) || (cmd == 8'h57) || (cmd == 8'h62) || (cmd == 8'h42);
        word  = (cmd == 8'h52) || (cmd == 8'h57);
        wr    = (cmd == 8'h57) || (cmd == 8'h42);
        exp_addr  = word ? {addr[23:1], 1'b0} : addr;
        exp_wdata = (cmd == 8'h57) ? wdata : {wdata[7:0], wdata[7:0]};

        if (!known) begin
            exp_tx.push_back(8'h3F);
        end else if (delay < 0) begin
            exp_tx.push_back(8'h54);
        end else if (cmd == 8'h52) begin
            exp_tx.push_back(rdata[15:8]);
            exp_tx.push_back(rdata[7:0]);
            exp_tx.push_back(8'h4B);
        end else if (cmd == 8'h62) begin
            exp_tx.push_back(addr[0] ? rdata[7:0] : rdata[15:8]);
            exp_tx.push_back(8'h4B);
        end else begin
            exp_tx.push_back(8'h4B);
        end

        frame.push_back(cmd);
        if (known) begin
            frame.push_back(addr[23:16]);
            frame.push_back(addr[15:8]);
            frame.push_back(addr[7:0]);
        end
        if (cmd == 8'h57) begin
            frame.push_back(wdata[15:8]);
            frame.push_back(wdata[7:0]);
        end
        if (cmd == 8'h42) frame.push_back(wdata[7:0]);

        ack_delay = delay;
        rd_data   = rdata;
        req_count = 0;
        txq.delete();

        foreach (frame[i]) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_byte(frame[i], dropped);
        end

        if (known) begin
            @(negedge clk);
            check_eq("req_latency", bus_req, 1'b1);
            if (inject) begin
                @(posedge clk);
                #1;
                send_byte(8'hA5, dropped);
                check_eq("rx_drop", dropped, 1'b1);
            end
        end

        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done", busy, 1'b0);

        if (known) begin
            check_eq("req_count", req_count, 1);
            check_eq("req_len", req_len, (delay < 0) ? TMO : delay + 1);
            check_eq("bus_addr", snap[42:19], exp_addr);
            check_eq("bus_rw", snap[18], !wr);
            check_eq("bus_uds", snap[17], word || !addr[0]);
            check_eq("bus_lds", snap[16], word || addr[0]);
            if (wr) check_eq("bus_wdata", snap[15:0], exp_wdata);
        end else begin
            check_eq("req_count", req_count, 0);
        end
        check_eq("tx_count", txq.size(), exp_tx.size());
        foreach (exp_tx[i]) begin
            if (i < txq.size()) check_eq("tx_byte", txq[i], exp_tx[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        logic        dropped;
        logic [7:0]  c;
        int          sel;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_bus", {bus_req, bus_rw, bus_uds, bus_lds, bus_addr, bus_data_write}, '0);
        check_eq("rst_tx", {tx_start, tx_data}, '0);
        check_eq("rst_busy", {busy, rx_drop}, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while a bus cycle is outstanding.
        ack_delay = -1;
        send_byte(8'h52, dropped);
        send_byte(8'h00, dropped);
        send_byte(8'h00, dropped);
        send_byte(8'h04, dropped);
        @(negedge clk);
        check_eq("rst_pre_req", bus_req, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_async_req", bus_req, 1'b0);
        check_eq("rst_async_txs", tx_start, 1'b0);
        check_eq("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_txn(8'h52, 24'h000004, 16'h0000, 16'h1234, 2, 1'b0);
        do_txn(8'h57, 24'h001003, 16'hABCD, 16'h0000, 3, 1'b0);
        do_txn(8'h62, 24'h000007, 16'h0000, 16'hAA55, 2, 1'b0);
        do_txn(8'h42, 24'h000006, 16'h005A, 16'h0000, 1, 1'b0);
        do_txn(8'h52, 24'hFF0000, 16'h0000, 16'h0000, -1, 1'b0);
        do_txn(8'h41, 24'h000000, 16'h0000, 16'h0000, 1, 1'b0);
        do_txn(8'h57, 24'h000100, 16'h1357, 16'h0000, 4, 1'b1);
        do_txn(8'h52, 24'h000010, 16'h0000, 16'hBEEF, 1, 1'b1);

        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: c = 8'h52;
                1: c = 8'h57;
                2: c = 8'h62;
                3: c = 8'h42;
                default: begin
                    do c = 8'($urandom);
                    while ((c == 8'h52) || (c == 8'h57) || (c == 8'h62) || (c == 8'h42));
                end
            endcase
            do_txn(c, 24'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 5),
                   ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
